// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU execute stage: data/opcode widths,
// result-file depth, the opcode map and the compare-result bit positions.
package cpu8_pkg;

  // Datapath and opcode widths.
  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  // Result file holds one entry per opcode.
  localparam int RF_DEPTH = 8;

  // Opcode map. The opcode value doubles as the result-file address.
  localparam logic [OP_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OP_W-1:0] OP_AND  = 3'd2;
  localparam logic [OP_W-1:0] OP_OR   = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_MUL  = 3'd5;
  localparam logic [OP_W-1:0] OP_DIV  = 3'd6;
  localparam logic [OP_W-1:0] OP_COMP = 3'd7;

  // Bit positions inside the compare result; all other bits read as zero.
  localparam int CMP_GT_BIT = 0;
  localparam int CMP_EQ_BIT = 1;
  localparam int CMP_LT_BIT = 2;

  // Quotient returned when dividing by zero (carry is raised alongside).
  localparam logic [DATA_W-1:0] DIV_ZERO_RES = 8'hFF;

  // Packed ALU response: flag plus result byte.
  typedef struct packed {
    logic              carry;
    logic [DATA_W-1:0] res;
  } alu_resp_t;

endpackage : cpu8_pkg

// File: rtl/instruction_memory_alu8.sv
// Purely combinational 8-bit ALU. Implements the eight operations of the
// execute stage, including the divide-by-zero substitution. The carry flag
// means carry (add), borrow (sub), high-byte-nonzero (mul) or error (div).
import cpu8_pkg::*;

module alu8 (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   sel,
  output logic [DATA_W-1:0] res,
  output logic              carry
);

  // Wide intermediates so the carry/borrow/overflow bits are explicit.
  logic [DATA_W:0]     sum;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quot;
  logic                div_zero;
  logic [DATA_W-1:0]   divisor;
  logic [DATA_W-1:0]   cmp_res;

  // Shared arithmetic: every operation is evaluated, sel picks one below.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    div_zero = (b == '0);
    // Substitute a divisor of 1 so the divider never sees zero; the result
    // is overridden below anyway when b is zero.
    divisor  = div_zero ? {{(DATA_W-1){1'b0}}, 1'b1} : b;
    quot     = a / divisor;
    cmp_res             = '0;
    cmp_res[CMP_GT_BIT] = (a > b);
    cmp_res[CMP_EQ_BIT] = (a == b);
    cmp_res[CMP_LT_BIT] = (a < b);
  end

  // Operation select: result byte and flag for the chosen opcode.
  always_comb begin
    res   = '0;
    carry = 1'b0;
    case (sel)
      OP_ADD: begin
        res   = sum[DATA_W-1:0];
        carry = sum[DATA_W];
      end
      OP_SUB: begin
        // The ninth bit of the wide difference is the borrow (a < b).
        res   = diff[DATA_W-1:0];
        carry = diff[DATA_W];
      end
      OP_AND: begin
        res = a & b;
      end
      OP_OR: begin
        res = a | b;
      end
      OP_XOR: begin
        res = a ^ b;
      end
      OP_MUL: begin
        res   = prod[DATA_W-1:0];
        carry = |prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        if (div_zero) begin
          res   = DIV_ZERO_RES;
          carry = 1'b1;
        end else begin
          res = quot;
        end
      end
      OP_COMP: begin
        res = cmp_res;
      end
      default: begin
        res   = '0;
        carry = 1'b0;
      end
    endcase
  end

endmodule : alu8

// File: rtl/instruction_memory.sv
// Execute stage of the 8-bit CPU: a two-stage registered ALU plus an
// 8-entry result file that remembers the last result of each opcode.
//
// Flow: there is no valid/ready handshake. Every rising edge accepts a new
// (a, b, opcode) triple and retires the one accepted on the previous edge,
// so the stage never stalls and results appear exactly two edges after
// their inputs. Reset is asynchronous and discards anything in flight.
import cpu8_pkg::*;

module instruction_memory (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   opcode,
  output logic [OP_W-1:0]   alu_sel,
  output logic [DATA_W-1:0] alu_out,
  output logic              carry_out,
  output logic [DATA_W-1:0] data_out
);

  // Operand pipeline registers (opcode register is the alu_sel output).
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;

  // Combinational ALU response for the operation held in the pipeline.
  logic [DATA_W-1:0] alu_res;
  logic              alu_carry;

  // Result file: one entry per opcode.
  logic [DATA_W-1:0] rf [RF_DEPTH];

  // Read port with write-first bypass.
  logic [DATA_W-1:0] rd_data;

  alu8 u_alu8 (
    .a     (a_r),
    .b     (b_r),
    .sel   (alu_sel),
    .res   (alu_res),
    .carry (alu_carry)
  );

  // Stage 1: capture operands and opcode every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      alu_sel <= '0;
    end else begin
      a_r     <= a;
      b_r     <= b;
      alu_sel <= opcode;
    end
  end

  // Stage 2: register the ALU result and its flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_out   <= '0;
      carry_out <= 1'b0;
    end else begin
      alu_out   <= alu_res;
      carry_out <= alu_carry;
    end
  end

  // Result file write: the retiring result lands in the entry of its opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        rf[i] <= '0;
      end
    end else begin
      rf[alu_sel] <= alu_res;
    end
  end

  // Read address selection: forward the result being written when it targets
  // the same entry, so the read sees the new value on the same edge.
  always_comb begin
    rd_data = rf[opcode];
    if (opcode == alu_sel) begin
      rd_data = alu_res;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= rd_data;
    end
  end

endmodule : instruction_memory

// File: tb/tb_instruction_memory.sv
// Bench for the execute stage: driver issues one operation per cycle and
// pushes the expected outputs for that edge into exp_q; a separate monitor
// pops one entry after each rising edge and compares.
module tb_instruction_memory;
  import cpu8_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [2:0] opcode = '0;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  instruction_memory dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .carry_out (carry_out),
    .data_out  (data_out)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {alu_sel[2:0], alu_out[7:0], carry_out, data_out[7:0]}
  logic [19:0] exp_q[$];
  logic [19:0] mon_e;
  int errors = 0;
  int checks = 0;

  // Reference model: the last result of each opcode, plus the operation
  // currently between capture and retirement.
  logic [7:0] rf_m [8];
  logic [7:0] pend_a;
  logic [7:0] pend_b;
  logic [2:0] pend_op;

  // ALU behaviour from the opcode table, using plain integer arithmetic.
  function automatic logic [8:0] alu_ref(input int x, input int y, input int op);
    int r;
    int c;
    r = 0;
    c = 0;
    case (op)
      0: begin r = (x + y) % 256; c = (x + y > 255) ? 1 : 0; end
      1: begin r = (x - y + 256) % 256; c = (x < y) ? 1 : 0; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = (x * y) % 256; c = ((x * y) / 256 != 0) ? 1 : 0; end
      6: begin
        if (y == 0) begin r = 255; c = 1; end
        else r = x / y;
      end
      default: r = ((x > y) ? 1 : 0) + ((x == y) ? 2 : 0) + ((x < y) ? 4 : 0);
    endcase
    return {c[0], r[7:0]};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 8; i++) rf_m[i] = '0;
    pend_a  = '0;
    pend_b  = '0;
    pend_op = '0;
  endtask

  // ---------------- driver ----------------
  // One call per clock; releases a pending reset at the same negedge so no
  // edge passes unmodelled.
  task automatic issue(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop);
    logic [8:0] wr;
    @(negedge clk);
    if (rst) begin
      rst = 1'b0;
      reset_model();
    end
    a      = ia;
    b      = ib;
    opcode = iop;
    // At the coming edge the pending operation retires into its entry, then
    // the entry named by iop is read (new value if they coincide).
    wr = alu_ref(pend_a, pend_b, pend_op);
    rf_m[pend_op] = wr[7:0];
    exp_q.push_back({iop, wr[7:0], wr[8], rf_m[iop]});
    pend_a  = ia;
    pend_b  = ib;
    pend_op = iop;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".alu_sel"},   {5'b0, alu_sel},   8'h00);
    check({tag, ".alu_out"},   alu_out,           8'h00);
    check({tag, ".carry_out"}, {7'b0, carry_out}, 8'h00);
    check({tag, ".data_out"},  data_out,          8'h00);
  endtask

  // Asynchronous pulse between edges; outputs must clear immediately.
  task automatic pulse_reset();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1;
    // Still in reset across an edge: nothing may move.
    check_all_zero("rst_hold");
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("alu_sel",   {5'b0, alu_sel},   {5'b0, mon_e[19:17]});
      check("alu_out",   alu_out,           mon_e[16:9]);
      check("carry_out", {7'b0, carry_out}, {7'b0, mon_e[8]});
      check("data_out",  data_out,          mon_e[7:0]);
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] dir_a  [13] = '{8'h05, 8'hCC, 8'h03, 8'h05, 8'hCC, 8'h05, 8'hCC,
                              8'h05, 8'h05, 8'hCC, 8'h5A, 8'h01, 8'h00};
  logic [7:0] dir_b  [13] = '{8'h03, 8'hAA, 8'h05, 8'h03, 8'hAA, 8'h03, 8'hAA,
                              8'h03, 8'h00, 8'hAA, 8'h5A, 8'h02, 8'h00};
  logic [2:0] dir_op [13] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
                              3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd0};

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    reset_model();
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("initial_rst");
    repeat (2) @(posedge clk);

    // Directed cases from the opcode table.
    for (int i = 0; i < 13; i++) issue(dir_a[i], dir_b[i], dir_op[i]);

    // All eight opcodes back-to-back, reset pulsed in the middle.
    for (int i = 0; i < 8; i++) begin
      issue(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 3'(i));
      if (i == 4) pulse_reset();
    end
    // Walk the read address upward: entries not yet rewritten must read 0.
    for (int i = 0; i < 8; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'(i));
    end

    // Randomized traffic with extra weight on b = 0 and a == b.
    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0:       rb = 8'h00;
        1:       rb = ra;
        default: rb = 8'($urandom_range(0, 255));
      endcase
      issue(ra, rb, 3'($urandom_range(0, 7)));
      if (i == 150) pulse_reset();
    end

    // Bounded drain of the scoreboard.
    repeat (4) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_instruction_memory
